// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: low-rate comb chain, zero-stuffing by R, full-rate
// integrator chain and a gain-normalising output shift.
module cic_interpolator #(
  parameter int INPUTWIDTH = 8,
  parameter int N          = 4,
  parameter int MAX_R      = 16,
  parameter int REGWIDTH   = INPUTWIDTH + N * $clog2(MAX_R)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(MAX_R):0]       R,
  input  logic signed [INPUTWIDTH-1:0] d_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [INPUTWIDTH-1:0] d_out,
  output logic                         out_valid,
  output logic                         underrun
);

  localparam int RW = $clog2(MAX_R) + 1;
  localparam int PW = (MAX_R > 1) ? $clog2(MAX_R) : 1;

  function automatic logic [7:0] log2_of(input logic [RW-1:0] r);
    logic [7:0] res;
    res = 8'd0;
    for (int b = 0; b < RW; b++) begin
      if (r[b]) begin
        res = 8'(b);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [PW-1:0]                p_q, p_d;
  logic [RW-1:0]                rl_q, rl_d, r_eff_s;
  logic signed [REGWIDTH-1:0]   comb_q [N];
  logic signed [REGWIDTH-1:0]   comb_d [N];
  logic signed [REGWIDTH-1:0]   integ_q [N];
  logic signed [REGWIDTH-1:0]   integ_d [N];
  logic signed [REGWIDTH-1:0]   y_s [N+1];
  logic signed [REGWIDTH-1:0]   c_reg_q, c_reg_d;
  logic signed [REGWIDTH-1:0]   x_s, stuff_s, shifted_s;
  logic                         fresh_q, fresh_d;
  logic                         underrun_q, underrun_d;
  logic                         out_valid_q, out_valid_d;
  logic [N:0]                   vpipe_q, vpipe_d;
  logic signed [INPUTWIDTH-1:0] d_out_q, d_out_d;
  logic                         slot_s;
  logic [7:0]                   sh_s;

  assign in_ready  = slot_s & ~rst;
  assign d_out     = d_out_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

  // Next-state logic: phase/ratio tracking, comb chain, integrators, output shift.
  always_comb begin
    slot_s  = (p_q == '0);
    r_eff_s = (R == '0) ? RW'(1) : R;
    // The ratio is only sampled at the start of a period so a period never changes length midway.
    rl_d    = slot_s ? r_eff_s : rl_q;
    if (RW'(p_q) + RW'(1) >= rl_d) begin
      p_d = '0;
    end else begin
      p_d = p_q + PW'(1);
    end

    x_s    = in_valid ? {{(REGWIDTH-INPUTWIDTH){d_in[INPUTWIDTH-1]}}, d_in} : '0;
    y_s[0] = x_s;
    for (int k = 0; k < N; k++) begin
      y_s[k+1]  = y_s[k] - comb_q[k];
      comb_d[k] = slot_s ? y_s[k] : comb_q[k];
    end
    c_reg_d = slot_s ? y_s[N] : c_reg_q;
    fresh_d = slot_s;

    stuff_s    = fresh_q ? c_reg_q : '0;
    integ_d[0] = integ_q[0] + stuff_s;
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end

    sh_s      = 8'(N - 1) * log2_of(rl_d);
    shifted_s = integ_q[N-1] >>> sh_s;
    d_out_d   = shifted_s[INPUTWIDTH-1:0];

    underrun_d  = slot_s & ~in_valid;
    // vpipe[0] goes sticky at the first accepted sample and walks out to the output latency.
    vpipe_d     = {vpipe_q[N-1:0], vpipe_q[0] | (slot_s & in_valid)};
    out_valid_d = vpipe_q[N];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      rl_q        <= RW'(1);
      c_reg_q     <= '0;
      fresh_q     <= 1'b0;
      underrun_q  <= 1'b0;
      out_valid_q <= 1'b0;
      vpipe_q     <= '0;
      d_out_q     <= '0;
      for (int k = 0; k < N; k++) begin
        comb_q[k]  <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      p_q         <= p_d;
      rl_q        <= rl_d;
      c_reg_q     <= c_reg_d;
      fresh_q     <= fresh_d;
      underrun_q  <= underrun_d;
      out_valid_q <= out_valid_d;
      vpipe_q     <= vpipe_d;
      d_out_q     <= d_out_d;
      for (int k = 0; k < N; k++) begin
        comb_q[k]  <= comb_d[k];
        integ_q[k] <= integ_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: closed-form reference (N-th slot difference, then
// binomial-weighted accumulation) compared every cycle, plus literal spot checks.
module tb_cic_interpolator;

  localparam int IW    = 8;
  localparam int N     = 4;
  localparam int MAX_R = 16;
  localparam int RW    = $clog2(MAX_R) + 1;
  localparam int REGW  = IW + N * $clog2(MAX_R);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RW-1:0]        R;
  logic signed [IW-1:0] d_in;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] d_out;
  logic                 out_valid;
  logic                 underrun;

  cic_interpolator #(.INPUTWIDTH(IW), .N(N), .MAX_R(MAX_R)) dut (
    .clk(clk), .rst(rst), .R(R), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready), .d_out(d_out), .out_valid(out_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int      m_p, m_rl, m_t, m_first;
  bit      m_started;
  longint  xs[$];
  int      ev_t[$];
  longint  ev_c[$];
  logic signed [IW-1:0] e_dout;
  logic    e_ov, e_ur;
  bit      cmp_dout = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint binom(input longint n, input int r);
    longint c;
    if (n < r) return 0;
    c = 1;
    for (int i = 0; i < r; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  function automatic longint wrap(input longint v);
    longint w;
    w = v & ((64'sd1 <<< REGW) - 64'sd1);
    if (w[REGW-1]) w = w - (64'sd1 <<< REGW);
    return w;
  endfunction

  task automatic model_reset();
    m_p = 0; m_rl = 1; m_t = 0; m_first = 0; m_started = 1'b0;
    xs.delete(); ev_t.delete(); ev_c.delete();
    e_dout = '0; e_ov = 1'b0; e_ur = 1'b0;
  endtask

  // Each slot contributes c = N-th difference of slot inputs; after N unit-delay
  // accumulators it weighs C(t-tau-1, N-1) in the last integrator after edge t.
  task automatic model_edge();
    int rl, l;
    longint acc, x, c;
    if (rst) begin
      model_reset();
    end else begin
      m_t++;
      rl = (m_p == 0) ? ((R == '0) ? 1 : int'(R)) : m_rl;
      m_rl = rl;
      acc = 0;
      foreach (ev_t[i]) acc += ev_c[i] * binom(longint'(m_t - 2 - ev_t[i]), N - 1);
      l = 0;
      while ((1 << l) < rl) l++;
      acc = wrap(acc) >>> ((N - 1) * l);
      e_dout = IW'(acc);
      e_ur = 1'b0;
      if (m_p == 0) begin
        x = in_valid ? longint'(d_in) : 0;
        xs.push_back(x);
        c = 0;
        for (int m = 0; m <= N; m++)
          if (xs.size() > m) c += ((m % 2) ? -1 : 1) * binom(N, m) * xs[xs.size() - 1 - m];
        ev_t.push_back(m_t);
        ev_c.push_back(wrap(c));
        e_ur = !in_valid;
        if (in_valid && !m_started) begin
          m_started = 1'b1;
          m_first = m_t;
        end
      end
      e_ov = m_started && (m_t >= m_first + N + 1);
      m_p = (m_p + 1 >= rl) ? 0 : m_p + 1;
    end
  endtask

  task automatic tick();
    #1;
    check("in_ready", in_ready, (m_p == 0 && !rst));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("no_x", $isunknown({d_out, out_valid, underrun, in_ready}), 0);
    if (cmp_dout) check("d_out", d_out, e_dout);
    check("out_valid", out_valid, e_ov);
    check("underrun", underrun, e_ur);
  endtask

  task automatic do_reset(input int cyc, input int r);
    rst = 1'b1; R = RW'(r); in_valid = 1'b0; d_in = '0;
    repeat (cyc) tick();
    rst = 1'b0;
  endtask

  initial begin
    int imp [6] = '{8, 32, 48, 32, 8, 0};
    int rsel [6] = '{0, 1, 2, 4, 8, 16};
    int t0, cnt;
    bit sent, dropped;

    rst = 1'b1; R = RW'(2); d_in = '0; in_valid = 1'b0;
    model_reset();
    @(negedge clk);

    // Impulse at R=2
    do_reset(2, 2);
    sent = 1'b0; t0 = -1;
    for (int k = 0; k < 24; k++) begin
      in_valid = 1'b1;
      if (!sent && m_p == 0) begin
        d_in = 8'sd64; sent = 1'b1; t0 = m_t + 1;
      end else begin
        d_in = 8'sd0;
      end
      tick();
      if (t0 >= 0 && m_t - t0 >= 5 && m_t - t0 <= 10)
        check("impulse_lit", d_out, imp[m_t - t0 - 5]);
    end

    // DC 10 at R=8
    do_reset(3, 8);
    in_valid = 1'b1; d_in = 8'sd10;
    repeat (64) tick();
    check("dc10_lit", d_out, 10);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      cnt += int'(in_ready);
    end
    check("dc10_ready_duty", cnt, 2);

    // Negative full-scale DC at R=16
    do_reset(3, 16);
    in_valid = 1'b1; d_in = 8'h80;
    repeat (128) tick();
    check("dcneg_lit", d_out, -128);

    // One dropped slot during DC 20 at R=4
    do_reset(3, 4);
    in_valid = 1'b1; d_in = 8'sd20;
    repeat (48) tick();
    check("dc20_lit", d_out, 20);
    cnt = 0; dropped = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!dropped && m_p == 0) begin
        in_valid = 1'b0; dropped = 1'b1;
      end else begin
        in_valid = 1'b1;
      end
      tick();
      cnt += int'(underrun);
      check("ur_out_valid_lit", out_valid, 1);
    end
    check("underrun_count", cnt, 1);

    // Ratio switch 4 -> 2 at DC 5, requested mid-period
    do_reset(3, 4);
    in_valid = 1'b1; d_in = 8'sd5;
    repeat (48) tick();
    check("dc5_lit", d_out, 5);
    while (m_p != 1) tick();
    R = RW'(2);
    cmp_dout = 1'b0;
    repeat (3) tick();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cnt += int'(in_ready);
    end
    check("rswitch_ready_duty", cnt, 4);
    cmp_dout = 1'b1;
    repeat (20) tick();

    // Reset held 3 cycles mid-stream
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_d_out", d_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_underrun", underrun, 0);
    repeat (10) tick();

    // Randomised segments
    for (int s = 0; s < 6; s++) begin
      do_reset(2, rsel[$urandom_range(0, 5)]);
      repeat (150) begin
        in_valid = ($urandom_range(0, 7) != 0);
        d_in = IW'($urandom);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
